// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - ALU response checker: golden compare, counters, verdict.
// Optional first-failure capture registers are built when ALU_CHK_CAPTURE_EN is defined.
module alu_resp_checker #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] dut_y,
  input  logic             dut_carry,
  output logic             mismatch,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_sel,
  output logic [WIDTH-1:0] fail_y
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_y;
  logic [2:0]       s1_sel;
  logic             s1_carry;
  logic [WIDTH:0]   golden;
  logic             bad;
  logic             xfer;
  logic             start_ok;

  assign in_ready = (state == RUN) && (acc_cnt < LAST_OP);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Bit WIDTH of the golden result is the carry (ADD) or borrow (SUB).
  always_comb begin
    golden = '0;
    case (s1_sel)
      3'b000:  golden = {1'b0, s1_a} + {1'b0, s1_b};
      3'b001:  golden = {1'b0, s1_a} - {1'b0, s1_b};
      3'b010:  golden = {1'b0, s1_a & s1_b};
      3'b011:  golden = {1'b0, s1_a | s1_b};
      3'b100:  golden = {1'b0, s1_a ^ s1_b};
      3'b101:  golden = {1'b0, ~(s1_a & s1_b)};
      3'b110:  golden = {1'b0, ~(s1_a | s1_b)};
      default: golden = {1'b0, ~(s1_a ^ s1_b)};
    endcase
  end

  assign bad = (golden != {s1_carry, s1_y});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_y     <= '0;
      s1_sel   <= '0;
      s1_carry <= 1'b0;
      mismatch <= 1'b0;
      op_cnt   <= '0;
      err_cnt  <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_sel   <= in_sel;
        s1_y     <= dut_y;
        s1_carry <= dut_carry;
      end
      mismatch <= s1_valid && bad;
      if (s1_valid) begin
        op_cnt <= op_cnt + 1'b1;
        if (bad && (err_cnt != CNT_MAX))
          err_cnt <= err_cnt + 1'b1;
      end
      // s1 is always empty in IDLE/DONE, so the start clear never races a count.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            acc_cnt <= '0;
            op_cnt  <= '0;
            err_cnt <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            acc_cnt <= acc_cnt + 1'b1;
            if ((acc_cnt + 1'b1) == LAST_OP)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CHK_CAPTURE_EN
  logic [WIDTH-1:0] cap_a, cap_b, cap_y;
  logic [2:0]       cap_sel;

  // err_cnt is still zero on the edge that records the first failure of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sel <= '0;
      cap_y   <= '0;
    end else if (start_ok) begin
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sel <= '0;
      cap_y   <= '0;
    end else if (s1_valid && bad && (err_cnt == '0)) begin
      cap_a   <= s1_a;
      cap_b   <= s1_b;
      cap_sel <= s1_sel;
      cap_y   <= s1_y;
    end
  end

  assign fail_a   = cap_a;
  assign fail_b   = cap_b;
  assign fail_sel = cap_sel;
  assign fail_y   = cap_y;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_sel = '0;
  assign fail_y   = '0;
`endif

endmodule

// File: doc/alu_resp_checker.md
Name: alu_resp_checker

Overview:
- Response-side companion to the 4-bit ALU: sits beside the ALU, consumes each applied operation (A, B, sel) together with the ALU's Y/carry, and computes the golden result.
- Flags mismatches, counts checked/failed operations, and reports a pass/fail verdict after a programmed number of operations.
- Used as an on-chip self-check and as the scoreboard in ALU benches.

Parameters:
- WIDTH, 4, operand/result width
- NUM_OPS, 8, operations to check per run (1..2^CNT_W-1)
- CNT_W, 8, width of op and error counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run (ignored unless IDLE or DONE)
- in_valid  in  1  operation + DUT response present this cycle
- in_ready  out  1  checker accepts this cycle
- in_a  in  WIDTH  operand A applied to ALU
- in_b  in  WIDTH  operand B applied to ALU
- in_sel  in  3  ALU opcode applied
- dut_y  in  WIDTH  ALU result Y for that operation
- dut_carry  in  1  ALU carry for that operation
- mismatch  out  1  one-cycle pulse per failing op
- op_cnt  out  CNT_W  operations checked this run
- err_cnt  out  CNT_W  mismatches this run, saturating
- done  out  1  run complete (level, held until next start)
- pass  out  1  done && err_cnt==0
- fail_a, fail_b  out  WIDTH  first failing operands (see Optional Feature)
- fail_sel  out  3  first failing opcode
- fail_y  out  WIDTH  first failing DUT result

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready, mismatch, done, pass = 0; op_cnt, err_cnt, fail_* = 0; pipeline valid bits cleared. Reset mid-run discards all in-flight ops.
- FSM IDLE -> RUN on start. RUN -> DRAIN when accepted count reaches NUM_OPS. DRAIN -> DONE when pipeline empty. DONE -> RUN on start, which clears counters, done, pass and fail_* in the same edge.
- in_ready = 1 only in RUN with accepted < NUM_OPS. Transfer on in_valid && in_ready; a transfer moves no data in any other case.
- Golden model, 5-bit result {carry,Y}:
  - 000 ADD: A+B
  - 001 SUB: A-B mod 2^(WIDTH+1); carry=1 means borrow
  - 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR, 111 XNOR: carry=0
- Pipeline, 2 stages:
  - Cycle T: transfer; stage 1 registers operands and DUT response.
  - Cycle T+1: golden computed, compare registered into stage 2.
  - mismatch asserts at T+2 for one cycle; op_cnt increments at T+2.
  - Back-to-back transfers every cycle are supported with no bubbles.
- err_cnt saturates at 2^CNT_W-1; op_cnt never exceeds NUM_OPS.
- done rises the cycle after the last op's compare stage. pass is registered with done.
- start during RUN/DRAIN: ignored.

Optional Feature:
- ALU_CHK_CAPTURE_EN defined:
  - fail_a/fail_b/fail_sel/fail_y load on the first mismatch of a run (same edge mismatch rises) and hold.
  - Later mismatches do not overwrite them.
  - They clear on start.
- Not defined: fail_* tied to 0, and no capture registers are built.

Test Plan:
- Reset then start, 8 ops A=0101 B=0011 sel 000..111 with correct DUT responses Y=1000,0010,0001,0111,0110,1110,1000,1001 carry all 0 -> mismatch never asserts; done=1, pass=1, op_cnt=8, err_cnt=0.
- Same sweep, but the sel=001 response is Y=0011 -> single mismatch pulse 2 cycles after that transfer; err_cnt=1, pass=0; with ALU_CHK_CAPTURE_EN: fail_a=0101, fail_b=0011, fail_sel=001, fail_y=0011.
- ADD A=1111 B=0001, DUT Y=0000 carry=1 -> no mismatch; SUB A=0000 B=0001, DUT Y=1111 carry=1 -> no mismatch.
- in_valid toggled 1-0-1 with gaps, plus a 9th valid op -> in_ready=0 after the 8th transfer, 9th not counted, op_cnt=8.
- rst_n pulsed low mid-run after 3 ops -> all outputs 0 immediately; no mismatch from flushed ops; new start runs cleanly.
- start pulsed while in RUN -> ignored, counters not cleared; start in DONE -> counters, done and pass cleared the next cycle.
